shift_out_reg: RTL
==================

// Module: shift_out_reg
// PURPOSE
//  Parallel-to-serial transmit shifter for the SPI block; the MISO-side counterpart of the
//  receive shift register. Accepts words over a valid/ready load port into a one-entry
//  holding buffer, then shifts them out MSB first, one bit per i_SHIFT_EN strobe, while
//  i_FRAME (chip-select active) is high. Supports back-to-back words without gaps.
// PARAMETERS
//  DATA_WIDTH   32    bits per word
//  IDLE_LEVEL   1'b0  value driven on o_D when not shifting
// PORTS
//  i_CLK         in   1           system clock, all logic on rising edge
//  i_RST_N       in   1           asynchronous reset, active low
//  i_LOAD_VALID  in   1           load request; word on i_LOAD_DATA is valid
//  o_LOAD_READY  out  1           holding buffer empty; = !hold_full
//  i_LOAD_DATA   in   DATA_WIDTH  word to transmit
//  i_FRAME       in   1           frame active (synchronised CS asserted), level
//  i_SHIFT_EN    in   1           1-cycle strobe per bit (SCLK shift-edge detect)
//  o_D           out  1           serial data out, registered
//  o_BUSY        out  1           high while state == SHIFT
//  o_DONE        out  1           1-cycle pulse: last bit of a word shifted out
//  o_UNDERRUN    out  1           1-cycle pulse: word ended, frame still high, buffer empty
//  o_ABORT       out  1           1-cycle pulse: i_FRAME dropped mid-word
// BEHAVIOUR
//  Reset (i_RST_N=0, async): state=IDLE, hold_full=0, cnt=0, sr=0, o_D=IDLE_LEVEL,
//   o_BUSY=0, o_DONE=0, o_UNDERRUN=0, o_ABORT=0; o_LOAD_READY=1. Reset mid-word discards all.
//  Load: accept when i_LOAD_VALID && o_LOAD_READY; hold<=i_LOAD_DATA, hold_full<=1 next edge.
//   Loading into hold is allowed in any state, including during SHIFT.
//  IDLE: o_D=IDLE_LEVEL; i_SHIFT_EN ignored. If hold_full && i_FRAME: sr<=hold,
//   hold_full<=0, cnt<=DATA_WIDTH-1, o_D<=hold[DATA_WIDTH-1], state<=SHIFT.
//   Latency: accept at edge N -> hold_full at N+1 -> MSB on o_D, o_BUSY=1 after edge N+2.
//  SHIFT, priority order per cycle:
//   1. !i_FRAME: state<=IDLE, o_D<=IDLE_LEVEL, o_ABORT pulse; sr discarded; hold kept.
//   2. i_SHIFT_EN && cnt!=0: sr<=sr<<1, o_D<=sr[DATA_WIDTH-2], cnt<=cnt-1.
//   3. i_SHIFT_EN && cnt==0: o_DONE pulse. If hold_full: reload as in IDLE, stay SHIFT
//      (no idle bit between words). Else: state<=IDLE, o_D<=IDLE_LEVEL, o_UNDERRUN pulse.
//   4. otherwise hold all state.
//  hold_full set (load) and cleared (transfer to sr) never coincide: ready=0 when full.
//  cnt width = $clog2(DATA_WIDTH); DATA_WIDTH>=2 required.
//  i_FRAME low + i_SHIFT_EN high same cycle in SHIFT: abort wins, no shift, no DONE.
//  o_DONE and o_UNDERRUN may pulse in the same cycle; o_ABORT never with o_DONE.
// TESTING
//  1. Reset, load 32'hA5A5_0F0F, FRAME=1, 32 SHIFT_EN strobes -> o_D serial
//     1010_0101_1010_0101_0000_1111_0000_1111, o_DONE once, o_UNDERRUN with it, o_D=0 after.
//  2. Load 32'h8000_0001, then 32'hFFFF_FFFF during shift -> 64 contiguous bits, 2 DONE
//     pulses, no UNDERRUN until second word ends; o_LOAD_READY low while hold full.
//  3. FRAME drops after 5 strobes of 32'hDEAD_BEEF -> o_ABORT 1 pulse, o_D=IDLE_LEVEL,
//     o_BUSY=0; next frame restarts with buffered word's MSB, not bit 26.
//  4. Assert i_RST_N=0 mid-word -> all outputs reset same cycle, o_LOAD_READY=1;
//     strobes in IDLE with FRAME=0 -> o_D stays IDLE_LEVEL.
//  5. SHIFT_EN with gaps of 0..7 idle cycles, random -> bit order identical to case 1.
//  6. IDLE_LEVEL=1, DATA_WIDTH=8, load 8'h00 -> o_D 1 idle, eight 0s, back to 1.

Source files
------------

// File: rtl/shift_out_reg.sv
// Parallel-to-serial transmit shifter: one-entry holding buffer loaded over valid/ready,
// shifted out MSB first on each shift strobe while the frame is active.
module shift_out_reg #(
    parameter int   DATA_WIDTH = 32,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_LOAD_VALID,
    output logic                  o_LOAD_READY,
    input  logic [DATA_WIDTH-1:0] i_LOAD_DATA,
    input  logic                  i_FRAME,
    input  logic                  i_SHIFT_EN,
    output logic                  o_D,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_UNDERRUN,
    output logic                  o_ABORT,
    output logic                  o_STATE
);

    localparam int CW = $clog2(DATA_WIDTH);

    // Load handshake: a word transfers on a rising edge where i_LOAD_VALID && o_LOAD_READY.
    // o_LOAD_READY depends only on the holding buffer, never on i_LOAD_VALID.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state, state_nx;
    logic                  hold_full, hold_full_nx;
    logic [DATA_WIDTH-1:0] hold, hold_nx;
    logic [DATA_WIDTH-1:0] sr, sr_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  d_q, d_nx;
    logic                  done_q, done_nx;
    logic                  underrun_q, underrun_nx;
    logic                  abort_q, abort_nx;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            hold       <= '0;
            sr         <= '0;
            cnt        <= '0;
            d_q        <= IDLE_LEVEL;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_full  <= hold_full_nx;
            hold       <= hold_nx;
            sr         <= sr_nx;
            cnt        <= cnt_nx;
            d_q        <= d_nx;
            done_q     <= done_nx;
            underrun_q <= underrun_nx;
            abort_q    <= abort_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hold_full_nx = hold_full;
        hold_nx      = hold;
        sr_nx        = sr;
        cnt_nx       = cnt;
        d_nx         = d_q;
        done_nx      = 1'b0;
        underrun_nx  = 1'b0;
        abort_nx     = 1'b0;

        // Load needs an empty buffer and reload needs a full one, so they never collide.
        if (i_LOAD_VALID && !hold_full) begin
            hold_nx      = i_LOAD_DATA;
            hold_full_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                d_nx = IDLE_LEVEL;
                if (hold_full && i_FRAME) begin
                    sr_nx        = hold;
                    hold_full_nx = 1'b0;
                    cnt_nx       = CW'(DATA_WIDTH - 1);
                    d_nx         = hold[DATA_WIDTH-1];
                    state_nx     = SHIFT;
                end
            end
            SHIFT: begin
                if (!i_FRAME) begin
                    state_nx = IDLE;
                    d_nx     = IDLE_LEVEL;
                    abort_nx = 1'b1;
                end else if (i_SHIFT_EN && cnt != '0) begin
                    sr_nx  = sr << 1;
                    d_nx   = sr[DATA_WIDTH-2];
                    cnt_nx = cnt - 1'b1;
                end else if (i_SHIFT_EN) begin
                    done_nx = 1'b1;
                    if (hold_full) begin
                        // Chain straight into the next word with no idle bit in between.
                        sr_nx        = hold;
                        hold_full_nx = 1'b0;
                        cnt_nx       = CW'(DATA_WIDTH - 1);
                        d_nx         = hold[DATA_WIDTH-1];
                    end else begin
                        state_nx    = IDLE;
                        d_nx        = IDLE_LEVEL;
                        underrun_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                d_nx     = IDLE_LEVEL;
            end
        endcase
    end

    assign o_LOAD_READY = !hold_full;
    assign o_D          = d_q;
    assign o_BUSY       = (state == SHIFT);
    assign o_DONE       = done_q;
    assign o_UNDERRUN   = underrun_q;
    assign o_ABORT      = abort_q;
    assign o_STATE      = state;

endmodule
